// File: rtl/shared_mem_ctrl.sv
// Round-robin arbitrated controller for the shared data memory.
// One request is accepted at a time: IDLE (grant) -> ACCESS (memory op) -> RESP (pulse).
module shared_mem_ctrl #(
    parameter int NUM_CORES  = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int MEM_SIZE   = 1024
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_CORES-1:0]                 req_valid,
    output logic [NUM_CORES-1:0]                 req_ready,
    input  logic [NUM_CORES-1:0]                 req_write,
    input  logic [NUM_CORES-1:0][ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_CORES-1:0][DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_CORES-1:0]                 resp_valid,
    output logic                                 resp_err,
    output logic [DATA_WIDTH-1:0]                resp_rdata,
    output logic                                 busy
);

    localparam int PTR_W = $clog2(NUM_CORES);
    localparam int IDX_W = $clog2(MEM_SIZE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [PTR_W-1:0]        r_rr_ptr;
    logic [PTR_W-1:0]        r_owner;
    logic                    r_write;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_err;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [DATA_WIDTH-1:0]   r_mem [MEM_SIZE];

    logic                    w_grant_any;
    logic [PTR_W-1:0]        w_grant_idx;
    logic [PTR_W-1:0]        w_cand_idx;
    logic [PTR_W-1:0]        w_rr_nxt;
    logic                    w_accept;
    logic                    w_misalign;
    logic                    w_out_of_range;
    logic                    w_acc_err;
    logic [IDX_W-1:0]        w_idx;

    // Decode the captured byte address into a word index and error flags
    always_comb begin
        w_misalign     = |r_addr[2:0];
        w_out_of_range = |r_addr[ADDR_WIDTH-1:3+IDX_W];
        w_acc_err      = w_misalign | w_out_of_range;
        w_idx          = r_addr[3 +: IDX_W];
    end

    // Round-robin search: first valid core starting at r_rr_ptr, wrapping modulo NUM_CORES
    always_comb begin
        int unsigned cand;
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_cand_idx  = '0;
        cand        = 0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            cand       = (32'(r_rr_ptr) + i) % NUM_CORES;
            w_cand_idx = PTR_W'(cand);
            if (!w_grant_any && req_valid[w_cand_idx]) begin
                w_grant_any = 1'b1;
                w_grant_idx = w_cand_idx;
            end
        end
        w_rr_nxt = (32'(w_grant_idx) + 1 == NUM_CORES) ? '0 : w_grant_idx + 1'b1;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and all externally visible outputs
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        resp_valid  = '0;
        resp_err    = 1'b0;
        resp_rdata  = '0;
        busy        = 1'b1;
        w_accept    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (w_grant_any) begin
                    req_ready[w_grant_idx] = 1'b1;
                    w_accept               = 1'b1;
                    w_state_nxt            = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                resp_valid[r_owner] = 1'b1;
                resp_err            = r_err;
                resp_rdata          = r_rdata;
                w_state_nxt         = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Capture the granted request, advance the pointer, and latch the access result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_write  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            if (w_accept) begin
                r_rr_ptr <= w_rr_nxt;
                r_owner  <= w_grant_idx;
                r_write  <= req_write[w_grant_idx];
                r_addr   <= req_addr[w_grant_idx];
                r_wdata  <= req_wdata[w_grant_idx];
            end
            if (r_state == ST_ACCESS) begin
                r_err   <= w_acc_err;
                r_rdata <= (w_acc_err || r_write) ? '0 : r_mem[w_idx];
            end
        end
    end

    // Memory array write; contents survive reset, and a reset during ACCESS
    // forces IDLE before the write edge so the write is dropped
    always_ff @(posedge clk) begin
        if (r_state == ST_ACCESS && r_write && !w_acc_err) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

endmodule

// File: tb/tb_shared_mem_ctrl.sv
// Scoreboard bench for shared_mem_ctrl: per-core request queues feed the ports,
// a negedge monitor checks grants against a round-robin model and responses
// against a word-level memory model.
module tb_shared_mem_ctrl;

    localparam int NC = 4;
    localparam int DW = 64;
    localparam int AW = 64;
    localparam int MS = 1024;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NC-1:0]        req_valid;
    logic [NC-1:0]        req_ready;
    logic [NC-1:0]        req_write;
    logic [NC-1:0][AW-1:0] req_addr;
    logic [NC-1:0][DW-1:0] req_wdata;
    logic [NC-1:0]        resp_valid;
    logic                 resp_err;
    logic [DW-1:0]        resp_rdata;
    logic                 busy;

    shared_mem_ctrl #(
        .NUM_CORES (NC),
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .MEM_SIZE  (MS)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_err  (resp_err),
        .resp_rdata(resp_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    typedef struct {
        int            core;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            cyc;
    } exp_t;

    req_t          cq [NC][$];
    exp_t          exp_q [$];
    logic [DW-1:0] m_mem [int unsigned];
    int            m_rr    = 0;
    int            hs_core = -1;
    int            cyc     = 0;
    int            n_vec   = 0;
    int            n_mis   = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NC-1:0] onehot(input int g);
        logic [NC-1:0] v;
        v = '0;
        if (g >= 0 && g < NC) v[g] = 1'b1;
        return v;
    endfunction

    function automatic logic acc_err(input logic [AW-1:0] a);
        return (a[2:0] != 3'd0) || (a[AW-1:3] >= MS);
    endfunction

    function automatic int pending();
        int p;
        p = exp_q.size() + $countones(req_valid) + int'(busy);
        for (int c = 0; c < NC; c++) p += cq[c].size();
        return p;
    endfunction

    task automatic post(input int c, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_t r;
        r.wr    = wr;
        r.addr  = a;
        r.wdata = d;
        cq[c].push_back(r);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (n < budget && pending() != 0) begin
            @(posedge clk);
            #4;
            n++;
        end
        chk("drain", 64'(pending()), '0);
    endtask

    // Asynchronous reset pulse from wherever the caller stands; checks outputs right after assertion
    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_busy",  64'(busy),       '0);
        chk("rst_ready", 64'(req_ready),  '0);
        chk("rst_rvld",  64'(resp_valid), '0);
        chk("rst_rerr",  64'(resp_err),   '0);
        chk("rst_rdata", resp_rdata,      '0);
        exp_q.delete();
        m_rr      = 0;
        hs_core   = -1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(posedge clk) cyc++;

    // Port driver: retire the handshaken request, then load the next queued one per core
    always @(posedge clk) begin
        req_t r;
        #1;
        if (hs_core >= 0) begin
            req_valid[hs_core] = 1'b0;
            hs_core = -1;
        end
        if (rst_n) begin
            for (int c = 0; c < NC; c++) begin
                if (!req_valid[c] && cq[c].size() > 0) begin
                    r = cq[c].pop_front();
                    req_write[c] = r.wr;
                    req_addr[c]  = r.addr;
                    req_wdata[c] = r.wdata;
                    req_valid[c] = 1'b1;
                end
            end
        end
    end

    // Monitor: grant model on handshake, scoreboard compare on response
    always @(negedge clk) begin
        int            g;
        exp_t          e;
        logic          er;
        int unsigned   idx;
        logic [DW-1:0] rd;
        if (rst_n) begin
            if (req_ready != '0) begin
                g = -1;
                for (int i = 0; i < NC; i++) begin
                    if (g < 0 && req_valid[(m_rr + i) % NC]) g = (m_rr + i) % NC;
                end
                chk("grant", 64'(req_ready), 64'(onehot(g)));
                if (g >= 0) begin
                    e.core  = g;
                    e.wr    = req_write[g];
                    e.addr  = req_addr[g];
                    e.wdata = req_wdata[g];
                    e.cyc   = cyc;
                    exp_q.push_back(e);
                    m_rr    = (g + 1) % NC;
                    hs_core = g;
                end
            end
            if (resp_valid != '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexp_resp", 64'(resp_valid), '0);
                end else begin
                    e   = exp_q.pop_front();
                    er  = acc_err(e.addr);
                    idx = int'(e.addr[12:3]);
                    rd  = '0;
                    if (!er && !e.wr) rd = m_mem.exists(idx) ? m_mem[idx] : '0;
                    chk("rvalid",  64'(resp_valid), 64'(onehot(e.core)));
                    chk("rerr",    64'(resp_err),   64'(er));
                    chk("rdata",   resp_rdata,      rd);
                    chk("latency", 64'(cyc),        64'(e.cyc + 2));
                    if (!er && e.wr) m_mem[idx] = e.wdata;
                end
            end else begin
                chk("quiet", resp_rdata | {{(DW-1){1'b0}}, resp_err}, '0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  64'(busy),       '0);
        chk("rst_ready", 64'(req_ready),  '0);
        chk("rst_rvld",  64'(resp_valid), '0);
        chk("rst_rerr",  64'(resp_err),   '0);
        chk("rst_rdata", resp_rdata,      '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Write then read back from a different core
        post(1, 1'b1, 64'h40, 64'hDEAD_BEEF_0000_0001);
        drain(50);
        post(2, 1'b0, 64'h40, '0);
        drain(50);

        // Seed words 0..3, one core at a time
        post(0, 1'b1, 64'h00, 64'h1111_0000_AAAA_0000);
        drain(50);
        post(1, 1'b1, 64'h08, 64'h2222_0000_BBBB_0008);
        drain(50);
        post(2, 1'b1, 64'h10, 64'h3333_0000_CCCC_0010);
        drain(50);
        post(3, 1'b1, 64'h18, 64'h4444_0000_DDDD_0018);
        drain(50);

        // Reset brings rr_ptr to 0 but keeps memory; all four cores read at once
        @(posedge clk);
        #3;
        pulse_reset();
        for (int c = 0; c < NC; c++) post(c, 1'b0, 64'(8 * c), '0);
        drain(100);

        // Core 0 streams reads; core 3 joins once and must not be starved
        for (int k = 0; k < 6; k++) post(0, 1'b0, 64'h40, '0);
        repeat (2) @(posedge clk);
        post(3, 1'b0, 64'h10, '0);
        drain(200);

        // Error cases: out-of-range write is not stored (index 1024 would alias word 0)
        post(0, 1'b1, 64'h2000, 64'hBAD0_BAD0_BAD0_BAD0);
        post(0, 1'b0, 64'h2004, '0);
        post(0, 1'b0, 64'h2000, '0);
        post(0, 1'b0, 64'h8000_0000_0000_0000, '0);
        post(0, 1'b1, 64'h0C, 64'h5555_5555_5555_5555);
        post(0, 1'b0, 64'h00, '0);
        drain(200);

        // Idle bus stays quiet
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            chk("idle_busy",  64'(busy),       '0);
            chk("idle_ready", 64'(req_ready),  '0);
            chk("idle_rvld",  64'(resp_valid), '0);
        end

        // Reset during ACCESS of a write: no response, write dropped, rr_ptr back to 0
        post(2, 1'b1, 64'h08, 64'hFFFF_EEEE_DDDD_CCCC);
        n = 0;
        while (n < 20 && !busy) begin
            @(posedge clk);
            #3;
            n++;
        end
        chk("busy_before_rst", 64'(busy), 64'd1);
        pulse_reset();
        repeat (3) @(negedge clk);
        post(3, 1'b0, 64'h08, '0);
        post(1, 1'b0, 64'h08, '0);
        drain(100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/shared_mem_ctrl.md
Name: shared_mem_ctrl

Overview:
- Round-robin arbitrated controller for the shared data memory used by the riscv_core instances.
- Each core issues word requests on a valid/ready channel. The controller accepts one request at a time, performs the read or write on an internal word-addressed array, then returns a one-cycle response pulse to the requesting core.
- Sits between the per-core memory ports and the shared data memory array, replacing the fixed-priority grant scheme.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..8).
- DATA_WIDTH, 64, data word width in bits.
- ADDR_WIDTH, 64, byte address width.
- MEM_SIZE, 1024, number of DATA_WIDTH words in the shared array (power of two).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  [NUM_CORES-1:0]  per-core request valid.
- req_ready  output  [NUM_CORES-1:0]  per-core request accepted (combinational, one-hot or zero).
- req_write  input  [NUM_CORES-1:0]  1 = write, 0 = read.
- req_addr  input  [NUM_CORES-1:0][ADDR_WIDTH-1:0]  byte address.
- req_wdata  input  [NUM_CORES-1:0][DATA_WIDTH-1:0]  write data.
- resp_valid  output  [NUM_CORES-1:0]  one-cycle response pulse to the owning core.
- resp_err  output  1  qualifies resp_valid: access was rejected.
- resp_rdata  output  [DATA_WIDTH-1:0]  read data; shared by all cores, qualified by resp_valid.
- busy  output  1  high when FSM is not IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - req_ready = 0 (combinational, FSM = IDLE), resp_valid = 0, resp_err = 0, resp_rdata = 0, busy = 0.
  - rr_ptr = 0; FSM = IDLE.
  - Memory array contents are not reset.
- FSM:
  - IDLE: if any req_valid, select the first core g with req_valid[g], searching rr_ptr, rr_ptr+1, … modulo NUM_CORES.
    - req_ready[g] = 1 in that same cycle.
    - On the clock edge, capture write, addr, wdata and g; set rr_ptr <= (g+1) mod NUM_CORES; go to ACCESS.
    - If no req_valid, stay in IDLE; rr_ptr is unchanged.
  - ACCESS: perform the memory operation on word index addr[ADDR_WIDTH-1:3]; go to RESP.
  - RESP: resp_valid[g] = 1 for exactly this cycle, resp_err and resp_rdata valid; go to IDLE.
- req_ready is 0 in ACCESS and RESP. A core must hold req_valid, req_write, req_addr and req_wdata stable until it sees req_ready.
- Latency:
  - A handshake in cycle T gives resp_valid in cycle T+2.
  - Maximum throughput is one request per 3 cycles.
  - A new acceptance can occur in the cycle after RESP at the earliest.
- Read: resp_rdata = mem[index]. Write: mem[index] <= wdata during ACCESS; resp_rdata = 0 on write responses.
- Error conditions (resp_err = 1, no memory write, resp_rdata = 0):
  - addr[2:0] != 0 (misaligned), or
  - addr[ADDR_WIDTH-1:3] >= MEM_SIZE (out of range, including any set upper bits).
- Outside RESP: resp_valid = 0, resp_err = 0, resp_rdata = 0.
- Simultaneous requests: exactly one grant per IDLE cycle. A core that drops req_valid before being granted loses nothing; no request state is kept for it.
- Fairness: with all cores requesting continuously, grants rotate g, g+1, …, and each core waits at most NUM_CORES-1 other accesses.
- Reset mid-operation (ACCESS or RESP):
  - Immediately return to IDLE; no resp_valid is issued.
  - A write in ACCESS is dropped unless its clock edge preceded the reset assertion.

Test Plan:
- Core 1 writes 0xDEAD_BEEF_0000_0001 to addr 0x40; later core 2 reads 0x40 -> core 2 gets resp_valid[2] 2 cycles after its handshake, rdata 0xDEAD_BEEF_0000_0001, resp_err 0.
- All 4 cores assert read req_valid in the same cycle after reset (rr_ptr = 0) -> req_ready grants 0,1,2,3 in order, 3 cycles apart; each resp_valid is one-hot on the matching core.
- Core 0 requests continuously while core 3 requests once -> core 3 is granted no later than its second eligible IDLE cycle; core 0 is never granted twice in a row while core 3 waits.
- Core 0 reads addr 0x2004 (misaligned), then addr 0x2000 (index 1024 = MEM_SIZE) -> both give resp_err 1 and rdata 0; a prior write to 0x2000 is not stored.
- Core 2 handshakes a write to 0x08, then rst_n is pulsed low during ACCESS -> outputs go to reset values asynchronously, no resp_valid is issued, and the next grant starts from core 0.
- Idle bus for 10 cycles -> busy 0, req_ready 0, resp_valid 0 throughout.
